// File: rtl/uart_pkg.sv
// Shared definitions for the UART report path: arbiter state encoding,
// ASCII constants used by the formatters, and a constant-width helper.
package uart_pkg;

  localparam int ST_W = 4;

  localparam logic [ST_W-1:0] S_IDLE      = 4'b0001;
  localparam logic [ST_W-1:0] S_ACCEPT    = 4'b0010;
  localparam logic [ST_W-1:0] S_WAIT_DONE = 4'b0100;
  localparam logic [ST_W-1:0] S_RELEASE   = 4'b1000;

  localparam logic [7:0] ASCII_CR   = 8'd13;
  localparam logic [7:0] ASCII_LF   = 8'd10;
  localparam logic [7:0] ASCII_SP   = 8'd32;
  localparam logic [7:0] ASCII_V    = 8'd86;
  localparam logic [7:0] ASCII_DASH = 8'd45;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot first request at or after ptr,
// wrapping to the lowest index when nothing at or above ptr is requesting.
import uart_pkg::*;

module rr_pick #(
  parameter int N_REQ = 2,
  parameter int PW    = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] pick,
  output logic             any
);

  logic [N_REQ-1:0] mask;
  logic [N_REQ-1:0] upper;
  logic [N_REQ-1:0] pool;
  logic             found;

  always_comb begin
    mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      mask[i] = (PW'(i) >= ptr);
    end
    upper = req & mask;
    pool  = (|upper) ? upper : req;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && pool[i]) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-granular arbiter in front of the UART byte transmitter: one owner at a
// time, released on its last byte, a length cap, or a mid-frame stall.
import uart_pkg::*;

module uart_tx_arbiter #(
  parameter int N_REQ     = 2,
  parameter int MAX_FRAME = 64,
  parameter int STALL_MAX = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  input  logic               tx_done_tick,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               frame_cut
);

  localparam int PW = clog2(N_REQ);
  localparam int BW = clog2(MAX_FRAME + 1);
  localparam int SW = clog2(STALL_MAX + 1);

  logic [ST_W-1:0]  state;
  logic [ST_W-1:0]  next_state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_after;
  logic [BW-1:0]    byte_cnt;
  logic [SW-1:0]    stall_cnt;
  logic             last_f;
  logic             cut;
  logic             cut_next;
  logic [N_REQ-1:0] pick;
  logic             any_req;
  logic             own_valid;
  logic             own_last;
  logic [7:0]       own_data;
  logic             accept;
  logic             stall_hit;
  logic             cap_hit;
  logic             tx_start_d;
  logic             frame_cut_d;
  logic [N_REQ-1:0] req_ready_d;

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .req  (req_valid),
    .ptr  (ptr),
    .pick (pick),
    .any  (any_req)
  );

  // grant is one-hot, so OR-ing the owned lanes selects the owner's signals.
  always_comb begin
    own_valid = |(req_valid & grant);
    own_last  = |(req_last & grant);
    own_data  = '0;
    ptr_after = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        own_data  = own_data | req_data[8*i +: 8];
        ptr_after = (i == N_REQ - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  assign accept    = (state == S_ACCEPT) && own_valid;
  assign stall_hit = (stall_cnt == SW'(STALL_MAX - 1));
  assign cap_hit   = (byte_cnt == BW'(MAX_FRAME));
  assign busy      = |grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    cut_next   = cut;
    case (state)
      S_IDLE: begin
        cut_next = 1'b0;
        if (any_req) next_state = S_ACCEPT;
      end
      S_ACCEPT: begin
        if (own_valid) begin
          next_state = S_WAIT_DONE;
        end else if (stall_hit) begin
          next_state = S_RELEASE;
          cut_next   = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (tx_done_tick) begin
          if (last_f) begin
            next_state = S_RELEASE;
            cut_next   = 1'b0;
          end else if (cap_hit) begin
            next_state = S_RELEASE;
            cut_next   = 1'b1;
          end else begin
            next_state = S_ACCEPT;
          end
        end
      end
      S_RELEASE: next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  always_comb begin
    tx_start_d  = accept;
    req_ready_d = accept ? grant : '0;
    frame_cut_d = (state == S_RELEASE) && cut;
  end

  // Strobes are registered so the transmitter and requesters see clean pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant     <= '0;
      ptr       <= '0;
      byte_cnt  <= '0;
      stall_cnt <= '0;
      last_f    <= 1'b0;
      cut       <= 1'b0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      req_ready <= '0;
      frame_cut <= 1'b0;
    end else begin
      tx_start  <= tx_start_d;
      req_ready <= req_ready_d;
      frame_cut <= frame_cut_d;
      cut       <= cut_next;
      case (state)
        S_IDLE: begin
          if (any_req) grant <= pick;
        end
        S_ACCEPT: begin
          if (own_valid) begin
            tx_data   <= own_data;
            last_f    <= own_last;
            stall_cnt <= '0;
            if (!cap_hit) byte_cnt <= byte_cnt + BW'(1);
          end else if (stall_cnt != SW'(STALL_MAX)) begin
            stall_cnt <= stall_cnt + SW'(1);
          end
        end
        S_RELEASE: begin
          grant     <= '0;
          ptr       <= ptr_after;
          byte_cnt  <= '0;
          stall_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
